// File: rtl/servo_pkg.sv
// Shared types and constants for the servo position controller.
package servo_pkg;

  typedef enum logic [1:0] {
    StDisabled,
    StHold,
    StMoving
  } servo_state_e;

  localparam logic [7:0] ANGLE_MAX    = 8'd180;
  localparam logic [7:0] ANGLE_CENTER = 8'd90;

  // Angle in degrees to pulse width in clocks; angles beyond the travel limit are clamped.
  function automatic logic [31:0] angle_to_width(input logic [7:0]  angle,
                                                 input logic [31:0] duty_min,
                                                 input logic [31:0] duty_per_deg);
    logic [7:0] a;
    a = (angle > ANGLE_MAX) ? ANGLE_MAX : angle;
    return duty_min + 32'(a) * duty_per_deg;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running PWM frame counter; frame_tick marks the last clock of each frame.
module frame_timer #(
  parameter int unsigned PERIOD_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int unsigned CntW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD_CYCLES - 1);

  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_tick  = (frame_cnt_q == CntLast);
    frame_cnt_d = frame_tick ? '0 : frame_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: rtl/servo_ctrl.sv
// Servo position controller: angle commands in, frame-aligned slewed duty values out to the PWM.
module servo_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = 500000,
  parameter int unsigned DUTY_MIN       = 12500,
  parameter int unsigned DUTY_PER_DEG   = 250,
  parameter int unsigned STEP_PER_FRAME = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_angle,
  output logic        cmd_ready,
  output logic [31:0] period,
  output logic [31:0] duty_cycle,
  output logic        at_target,
  output logic        busy
);

  localparam logic [31:0] Step        = 32'(STEP_PER_FRAME);
  localparam logic [31:0] CenterWidth =
      angle_to_width(ANGLE_CENTER, 32'(DUTY_MIN), 32'(DUTY_PER_DEG));

  servo_state_e state_q, state_d;
  logic [31:0]  cur_q, cur_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  duty_q, duty_d;
  logic         at_target_q;
  logic         frame_tick;
  logic         transfer;
  logic [31:0]  cmd_width;
  logic [31:0]  diff;
  logic [31:0]  stepped;

  frame_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_frame_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick)
  );

  always_comb begin
    period     = 32'(PERIOD_CYCLES);
    cmd_ready  = (state_q != StMoving);
    busy       = (state_q == StMoving);
    duty_cycle = duty_q;
    at_target  = at_target_q;
  end

  always_comb begin
    cmd_width = angle_to_width(cmd_angle, 32'(DUTY_MIN), 32'(DUTY_PER_DEG));
    transfer  = cmd_valid && cmd_ready;
    tgt_d     = transfer ? cmd_width : tgt_q;

    // Subtract the smaller from the larger so the step can never wrap past the target.
    if (tgt_q >= cur_q) begin
      diff    = tgt_q - cur_q;
      stepped = cur_q + ((diff > Step) ? Step : diff);
    end else begin
      diff    = cur_q - tgt_q;
      stepped = cur_q - ((diff > Step) ? Step : diff);
    end

    cur_d = cur_q;
    if (state_q == StMoving && enable && frame_tick) begin
      cur_d = stepped;
    end

    duty_d = duty_q;
    if (frame_tick) begin
      duty_d = (state_q == StDisabled) ? 32'd0 : cur_d;
    end

    state_d = state_q;
    unique case (state_q)
      StDisabled: begin
        // Compare against the incoming target so a command taken while disabled is not lost.
        if (enable) state_d = (cur_q == tgt_d) ? StHold : StMoving;
      end
      StHold: begin
        if (!enable) begin
          state_d = StDisabled;
        end else if (transfer && (cmd_width != cur_q)) begin
          state_d = StMoving;
        end
      end
      StMoving: begin
        if (!enable) begin
          state_d = StDisabled;
        end else if (frame_tick && (cur_d == tgt_q)) begin
          state_d = StHold;
        end
      end
      default: state_d = StDisabled;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StDisabled;
      cur_q       <= CenterWidth;
      tgt_q       <= CenterWidth;
      duty_q      <= 32'd0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      duty_q      <= duty_d;
      at_target_q <= (cur_d == tgt_d);
    end
  end

endmodule

// File: tb/tb_servo_ctrl.sv
// Directed self-checking bench for servo_ctrl with a 100-clock frame and 4-clock slew step.
module tb_servo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_angle = 8'd0;
  logic        cmd_ready;
  logic [31:0] period;
  logic [31:0] duty_cycle;
  logic        at_target;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int tb_cnt = 0;

  servo_ctrl #(
    .PERIOD_CYCLES (100),
    .DUTY_MIN      (10),
    .DUTY_PER_DEG  (1),
    .STEP_PER_FRAME(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cmd_valid (cmd_valid),
    .cmd_angle (cmd_angle),
    .cmd_ready (cmd_ready),
    .period    (period),
    .duty_cycle(duty_cycle),
    .at_target (at_target),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Independent frame position: 99 means the coming edge is a frame tick.
  always @(posedge clk) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == 99) ? 0 : tb_cnt + 1;
  end

  // Returns just after the next tick edge.
  task automatic next_tick();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tb_cnt == 0) return;
    end
    checks++; errors++;
    $display("FAIL tick_timeout got no tick in 200 cycles");
  endtask

  task automatic send(input logic [7:0] angle);
    cmd_valid = 1'b1;
    cmd_angle = angle;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_angle = 8'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (period !== 32'd100) begin errors++; $display("FAIL rst_period got %0d exp 100", period); end
    checks++; if (duty_cycle !== 32'd0) begin errors++; $display("FAIL rst_duty got %0d exp 0", duty_cycle); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL rst_at_target got %b exp 1", at_target); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (duty_cycle !== 32'd0) begin errors++; $display("FAIL pre_tick_duty got %0d exp 0", duty_cycle); end
    checks++; if (period !== 32'd100) begin errors++; $display("FAIL run_period got %0d exp 100", period); end
    next_tick();
    checks++; if (duty_cycle !== 32'd100) begin errors++; $display("FAIL first_tick_duty got %0d exp 100", duty_cycle); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL en_at_target got %b exp 1", at_target); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy got %b exp 0", busy); end
  endtask

  task automatic test_move();
    int exp_w[5] = '{104, 108, 112, 116, 118};
    send(8'd108);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL move_ready got %b exp 0", cmd_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL move_busy got %b exp 1", busy); end
    checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL move_at_target got %b exp 0", at_target); end
    for (int i = 0; i < 5; i++) begin
      next_tick();
      checks++;
      if (duty_cycle !== 32'(exp_w[i])) begin
        errors++; $display("FAIL move_duty step %0d got %0d exp %0d", i, duty_cycle, exp_w[i]);
      end
    end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL move_done_ready got %b exp 1", cmd_ready); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL move_done_at got %b exp 1", at_target); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL move_done_busy got %b exp 0", busy); end
  endtask

  task automatic test_clamp_reverse();
    send(8'd200);
    for (int w = 122; w <= 190; w += 4) begin
      next_tick();
      checks++;
      if (duty_cycle !== 32'(w)) begin errors++; $display("FAIL clamp_duty got %0d exp %0d", duty_cycle, w); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clamp_busy got %b exp 0", busy); end
    send(8'd0);
    for (int w = 186; w >= 10; w -= 4) begin
      next_tick();
      checks++;
      if (duty_cycle !== 32'(w)) begin errors++; $display("FAIL reverse_duty got %0d exp %0d", duty_cycle, w); end
    end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL reverse_at got %b exp 1", at_target); end
    next_tick();
    checks++; if (duty_cycle !== 32'd10) begin errors++; $display("FAIL floor_duty got %0d exp 10", duty_cycle); end
  endtask

  task automatic test_disable();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(8'd108);
    next_tick();
    checks++; if (duty_cycle !== 32'd104) begin errors++; $display("FAIL dis_step1 got %0d exp 104", duty_cycle); end
    next_tick();
    checks++; if (duty_cycle !== 32'd108) begin errors++; $display("FAIL dis_step2 got %0d exp 108", duty_cycle); end
    enable = 1'b0;
    next_tick();
    checks++; if (duty_cycle !== 32'd0) begin errors++; $display("FAIL dis_duty got %0d exp 0", duty_cycle); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL dis_ready got %b exp 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy got %b exp 0", busy); end
    next_tick();
    checks++; if (duty_cycle !== 32'd0) begin errors++; $display("FAIL dis_hold got %0d exp 0", duty_cycle); end
    enable = 1'b1;
    next_tick();
    checks++; if (duty_cycle !== 32'd112) begin errors++; $display("FAIL resume got %0d exp 112", duty_cycle); end
    next_tick();
    next_tick();
    checks++; if (duty_cycle !== 32'd118) begin errors++; $display("FAIL resume_end got %0d exp 118", duty_cycle); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL resume_at got %b exp 1", at_target); end
  endtask

  task automatic test_tick_transfer();
    int exp_w[5] = '{114, 110, 106, 102, 100};
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tb_cnt == 99) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL tt_align got no tick slot exp slot"); end
    send(8'd90);
    checks++; if (duty_cycle !== 32'd118) begin errors++; $display("FAIL tt_old_tgt got %0d exp 118", duty_cycle); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tt_busy got %b exp 1", busy); end
    for (int i = 0; i < 5; i++) begin
      next_tick();
      checks++;
      if (duty_cycle !== 32'(exp_w[i])) begin
        errors++; $display("FAIL tt_duty step %0d got %0d exp %0d", i, duty_cycle, exp_w[i]);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tt_done_busy got %b exp 0", busy); end
  endtask

  task automatic test_same_angle();
    bit seen_busy = 1'b0;
    send(8'd90);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %b exp 1", cmd_ready); end
    for (int i = 0; i < 120; i++) begin
      if (busy !== 1'b0) seen_busy = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen_busy) begin errors++; $display("FAIL same_busy got 1 exp 0"); end
    checks++; if (duty_cycle !== 32'd100) begin errors++; $display("FAIL same_duty got %0d exp 100", duty_cycle); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL same_at got %b exp 1", at_target); end
  endtask

  task automatic test_reset_mid_move();
    send(8'd108);
    next_tick();
    checks++; if (duty_cycle !== 32'd104) begin errors++; $display("FAIL rmm_step got %0d exp 104", duty_cycle); end
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (duty_cycle !== 32'd0) begin errors++; $display("FAIL rmm_duty got %0d exp 0", duty_cycle); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmm_busy got %b exp 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmm_ready got %b exp 1", cmd_ready); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL rmm_at got %b exp 1", at_target); end
    rst_n = 1'b1;
    next_tick();
    checks++; if (duty_cycle !== 32'd100) begin errors++; $display("FAIL rmm_center got %0d exp 100", duty_cycle); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmm_post_busy got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_move();
    test_clamp_reverse();
    test_disable();
    test_tick_transfer();
    test_same_angle();
    test_reset_mid_move();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
